// File: rtl/key_edge_detect_multi.sv
// Multi-channel key conditioner: per-channel 2-FF synchroniser, stable-count debouncer,
// mode-selectable one-cycle edge event, and a tie flag when several events coincide.
module key_edge_detect_multi #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = $clog2(DEBOUNCE + 1)
) (
    input  logic            CLOCK,
    input  logic            Reset,
    input  logic [N_CH-1:0] KEY,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] out,
    output logic            tie
);

    localparam logic [1:0] ModeRelease = 2'b00;
    localparam logic [1:0] ModePress   = 2'b01;
    localparam logic [1:0] ModeBoth    = 2'b10;

    // Last count value before the level is allowed to flip.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);

    logic [N_CH-1:0]  s1_q, s2_q;
    logic [N_CH-1:0]  level_q, level_d;
    logic [N_CH-1:0]  out_q, out_d;
    logic             tie_q, tie_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  flip;
    logic [N_CH-1:0]  rise, fall;
    logic             press_en, release_en;

    // Debounce: count consecutive mismatch cycles, flip the level once the run is long enough.
    always_comb begin
        flip = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    flip[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        level_d = level_q ^ flip;
    end

    // Event qualification by mode, and tie detection on the next-cycle event vector.
    always_comb begin
        rise       = flip & level_d;
        fall       = flip & ~level_d;
        press_en   = (mode == ModePress) || (mode == ModeBoth);
        release_en = (mode == ModeRelease) || (mode == ModeBoth);
        out_d      = (rise & {N_CH{press_en}}) | (fall & {N_CH{release_en}});
        tie_d      = 1'b0;
        // Running "seen one already" flag gives popcount >= 2 without an adder tree.
        begin
            logic seen;
            seen = 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (out_d[i]) begin
                    if (seen) begin
                        tie_d = 1'b1;
                    end
                    seen = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            out_q   <= '0;
            tie_q   <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= KEY;
            s2_q    <= s1_q;
            level_q <= level_d;
            out_q   <= out_d;
            tie_q   <= tie_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level = level_q;
    assign out   = out_q;
    assign tie   = tie_q;

endmodule

// File: doc/key_edge_detect_multi.md
Name: key_edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-player key edge detector.
- Each of N_CH raw push-button inputs goes through a 2-FF synchroniser and a stable-count debouncer.
- Each channel produces a debounced level and a one-cycle event pulse; the event is selectable as release, press, either edge, or off.
- Sits between the board KEY pins and the tug-of-war game FSM. It also flags same-cycle events from two or more players (tie).

Parameters:
- N_CH, 2, number of independent key channels (≥1).
- DEBOUNCE, 4, consecutive cycles the synchronised input must differ from the debounced level before the level flips (≥1).
- CNT_W, $clog2(DEBOUNCE+1), width of each per-channel debounce counter.

Ports:
- CLOCK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on CLOCK rising edge.
- KEY  input  N_CH  raw key inputs, asynchronous to CLOCK, 1 = pressed.
- mode  input  2  event select, common to all channels: 00 release (legacy), 01 press, 10 both edges, 11 events disabled.
- level  output  N_CH  debounced, registered key state per channel.
- out  output  N_CH  registered one-cycle event pulse per channel.
- tie  output  1  registered; high for one cycle when two or more bits of out are high in that cycle.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - sync stages s1/s2, level, counters, out and tie all go to 0.
  - Applies mid-debounce; partially counted transitions are discarded.
  - While Reset==0, out and tie stay 0.
- Synchroniser: s1[i] <= KEY[i]; s2[i] <= s1[i]. Logic after s2 never sees raw KEY.
- Debounce, per channel i, each edge:
  - If s2[i]==level[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE-1: level[i] <= s2[i], cnt[i] <= 0, and a transition is flagged.
  - Else: cnt[i] <= cnt[i]+1.
  - Any mismatch run shorter than DEBOUNCE cycles leaves level unchanged and resets cnt.
- Latency: the first edge sampling KEY high is edge 0. level[i] and any out[i] pulse become visible after edge DEBOUNCE+1. Example: DEBOUNCE=4 means visible after edge 5.
- Event: out[i] <= transition[i] qualified by mode sampled at the same edge.
  - 00: only 1→0 transitions.
  - 01: only 0→1 transitions.
  - 10: both.
  - 11: none.
  - out[i] is otherwise 0; it is never high for two consecutive cycles.
- Mode change: takes effect on the next edge. level is unaffected by mode.
- Holding a key pressed indefinitely produces exactly one press event (mode 01/10) and no repeats. Releasing produces one release event (mode 00/10).
- tie <= (popcount of next out ≥2). It is registered in the same cycle as out, so tie and the out pulses align.
- Channels are fully independent apart from mode and tie.
- No internal state depends on N_CH beyond replication. Counter width CNT_W must hold DEBOUNCE-1 without overflow.

Test Plan:
- Reset then idle: hold Reset=0 for 3 cycles, KEY=0 → level=0, out=0, tie=0. Then set KEY[0]=1 with Reset=0 held → out stays 0.
- Clean press/release, DEBOUNCE=4, mode=00:
  - KEY[0] 0→1 before edge 0 → level[0]=1 after edge 5, out[0]=0 throughout.
  - KEY[0] 1→0 → level[0]=0 five edges later, out[0] high for exactly 1 cycle.
- Glitch rejection, mode=10: KEY[1] high for 3 cycles, then low → level[1] stays 0, out[1] never asserts, cnt returns to 0.
- Mode sweep:
  - mode=01, press then release KEY[0] → one out[0] pulse, on press.
  - mode=10 → two pulses.
  - mode=11 → zero pulses, while level[0] still toggles.
- Tie, mode=01: KEY[0] and KEY[1] rise before the same edge → out=2'b11 and tie=1 for one cycle. Repeating with KEY[1] one cycle later → two separate single-bit pulses, tie=0.
- Reset mid-debounce: KEY[0]=1 for 3 cycles, Reset=0 for 1 cycle, Reset=1 with KEY[0] still high → level[0] rises DEBOUNCE+2 edges after reset release, not earlier.
